// File: rtl/mux_scan_sel_pkg.sv
// Shared definitions for the scanning channel selector.
package mux_scan_sel_pkg;

   // Selector operating mode as seen on the mode input.
   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_SCAN   = 1'b1
   } mode_e;

endpackage

// File: rtl/mux_scan_sel_rr_next_ch.sv
// Round-robin channel finder: first set bit of mask at or above ptr,
// wrapping from NUM_CH-1 back to 0. Purely combinational.
module rr_next_ch
   import mux_scan_sel_pkg::*;
#(
   parameter int unsigned NUM_CH = 8,
   parameter int unsigned SEL_W  = $clog2(NUM_CH)
)
(
   input  logic [SEL_W-1:0]  i_ptr,
   input  logic [NUM_CH-1:0] i_mask,
   output logic              o_found,
   output logic [SEL_W-1:0]  o_idx
);

   // Rotate-by-ptr, priority-encode, unrotate folded into one upward walk.
   always_comb begin : search
      logic [SEL_W:0] w_pos;
      o_found = 1'b0;
      o_idx   = '0;
      w_pos   = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         w_pos = {1'b0, i_ptr} + (SEL_W+1)'(i);
         if (w_pos >= (SEL_W+1)'(NUM_CH)) begin
            w_pos = w_pos - (SEL_W+1)'(NUM_CH);
         end
         if (!o_found && i_mask[w_pos[SEL_W-1:0]]) begin
            o_found = 1'b1;
            o_idx   = w_pos[SEL_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mux_scan_sel.sv
// N:1 channel selector with registered valid/ready output stage.
// Manual mode outputs the pointed channel; scan mode round-robins over
// enabled channels starting from the pointer.
module mux_scan_sel
   import mux_scan_sel_pkg::*;
#(
   parameter int unsigned NUM_CH = 8,
   parameter int unsigned DATA_W = 1,
   parameter int unsigned SEL_W  = $clog2(NUM_CH)
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH*DATA_W-1:0] i_in,
   input  logic [NUM_CH-1:0]        i_ch_en,
   input  logic                     i_mode,
   input  logic [SEL_W-1:0]         i_sel_in,
   input  logic                     i_sel_load,
   output logic [DATA_W-1:0]        o_out_data,
   output logic [SEL_W-1:0]         o_out_sel,
   output logic                     o_out_valid,
   input  logic                     i_out_ready,
   output logic                     o_sel_err
);

   logic [SEL_W-1:0]  r_ptr;
   logic [DATA_W-1:0] r_data;
   logic [SEL_W-1:0]  r_sel;
   logic              r_valid;
   logic              r_err;

   mode_e             w_mode;
   logic              w_scan_found;
   logic [SEL_W-1:0]  w_scan_idx;
   logic [SEL_W-1:0]  w_cand;
   logic              w_cand_ok;
   logic [DATA_W-1:0] w_cand_data;
   logic              w_slot_free;
   logic              w_load;
   logic              w_sel_ok;
   logic [SEL_W:0]    w_cand_inc;
   logic [SEL_W-1:0]  w_ptr_adv;

   assign w_mode = mode_e'(i_mode);

   rr_next_ch #(
      .NUM_CH (NUM_CH),
      .SEL_W  (SEL_W)
   ) u_rr (
      .i_ptr   (r_ptr),
      .i_mask  (i_ch_en),
      .o_found (w_scan_found),
      .o_idx   (w_scan_idx)
   );

   assign w_cand      = (w_mode == MODE_SCAN) ? w_scan_idx : r_ptr;
   assign w_cand_ok   = (w_mode == MODE_SCAN) ? w_scan_found : i_ch_en[r_ptr];
   assign w_slot_free = !r_valid || i_out_ready;
   assign w_load      = w_slot_free && w_cand_ok;
   assign w_sel_ok    = ({1'b0, i_sel_in} < (SEL_W+1)'(NUM_CH));
   assign w_cand_inc  = {1'b0, w_cand} + (SEL_W+1)'(1);
   assign w_ptr_adv   = (w_cand_inc == (SEL_W+1)'(NUM_CH)) ? '0 : w_cand_inc[SEL_W-1:0];

   // Pick the candidate channel's sample out of the packed input bus.
   always_comb begin : cand_data
      w_cand_data = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (w_cand == SEL_W'(k)) begin
            w_cand_data = i_in[k*DATA_W +: DATA_W];
         end
      end
   end

   // Output register: capture on a free slot, drop valid if nothing to send.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_sel   <= '0;
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_data  <= w_cand_data;
         r_sel   <= w_cand;
         r_valid <= 1'b1;
      end else if (w_slot_free) begin
         r_valid <= 1'b0;
      end
   end

   // Pointer: a valid host load beats the scan advance; bad loads flag an error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
         r_err <= 1'b0;
      end else begin
         r_err <= i_sel_load && !w_sel_ok;
         if (i_sel_load) begin
            if (w_sel_ok) begin
               r_ptr <= i_sel_in;
            end
         end else if (w_load && (w_mode == MODE_SCAN)) begin
            r_ptr <= w_ptr_adv;
         end
      end
   end

   assign o_out_data  = r_data;
   assign o_out_sel   = r_sel;
   assign o_out_valid = r_valid;
   assign o_sel_err   = r_err;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Scoreboard bench for mux_scan_sel with a 6-channel, 4-bit configuration.
module tb_mux_scan_sel;

   localparam int N  = 6;
   localparam int DW = 4;
   localparam int SW = 3;

   typedef struct {
      logic [DW-1:0] d;
      logic [SW-1:0] s;
   } xfer_t;

   typedef struct {
      logic v;
      logic e;
   } rec_t;

   logic            clk;
   logic            rst_n;
   logic [N*DW-1:0] t_in;
   logic [N-1:0]    t_en;
   logic            t_mode;
   logic [SW-1:0]   t_sel_in;
   logic            t_load;
   logic            t_ready;
   logic [DW-1:0]   o_data;
   logic [SW-1:0]   o_sel;
   logic            o_valid;
   logic            o_err;

   int    n_checks;
   int    n_fail;
   bit    chk_en;
   xfer_t tq[$];
   rec_t  rq[$];

   // Reference state: pointer and whether a sample is held.
   int    m_ptr;
   bit    m_valid;

   mux_scan_sel #(
      .NUM_CH (N),
      .DATA_W (DW),
      .SEL_W  (SW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in        (t_in),
      .i_ch_en     (t_en),
      .i_mode      (t_mode),
      .i_sel_in    (t_sel_in),
      .i_sel_load  (t_load),
      .o_out_data  (o_data),
      .o_out_sel   (o_sel),
      .o_out_valid (o_valid),
      .i_out_ready (t_ready),
      .o_sel_err   (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endfunction

   function automatic bit en_bit(input int k);
      logic [N-1:0] sh;
      sh = t_en >> k;
      return sh[0];
   endfunction

   // Expected behaviour for one clock edge, from the input values held across it.
   task automatic model_step();
      bit    free;
      bit    found;
      bit    err;
      int    c;
      xfer_t x;
      free  = !m_valid || t_ready;
      found = 0;
      c     = m_ptr;
      err   = 0;
      if (t_mode) begin
         for (int i = 0; i < N; i++) begin
            if (!found && en_bit((m_ptr + i) % N)) begin
               found = 1;
               c     = (m_ptr + i) % N;
            end
         end
      end else begin
         found = en_bit(m_ptr);
      end
      if (free) begin
         if (found) begin
            m_valid = 1;
            x.d = DW'(t_in >> (c * DW));
            x.s = SW'(c);
            tq.push_back(x);
         end else begin
            m_valid = 0;
         end
      end
      if (t_load) begin
         if (int'(t_sel_in) < N) m_ptr = int'(t_sel_in);
         else err = 1;
      end else if (free && found && t_mode) begin
         m_ptr = (c + 1) % N;
      end
      rq.push_back('{v: m_valid, e: err});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic model_reset();
      m_ptr   = 0;
      m_valid = 0;
      tq.delete();
      rq.delete();
   endtask

   // Monitor: mid-cycle, compare visible state against the scoreboard.
   always @(negedge clk) begin
      rec_t r;
      if (chk_en) begin
         if (rq.size() == 0) begin
            chk("record_available", 0, 1);
         end else begin
            r = rq.pop_front();
            chk("out_valid", {31'd0, o_valid}, {31'd0, r.v});
            chk("sel_err", {31'd0, o_err}, {31'd0, r.e});
            if (r.v) begin
               if (tq.size() == 0) begin
                  chk("sample_queued", 0, 1);
               end else begin
                  chk("out_data", {28'd0, o_data}, {28'd0, tq[0].d});
                  chk("out_sel", {29'd0, o_sel}, {29'd0, tq[0].s});
                  if (t_ready) void'(tq.pop_front());
               end
            end
         end
      end
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      chk_en   = 0;
      t_in     = '0;
      t_en     = '1;
      t_mode   = 1'b0;
      t_sel_in = '0;
      t_load   = 1'b0;
      t_ready  = 1'b1;
      rst_n    = 1'b1;
      model_reset();
      #2 rst_n = 1'b0;
      #10;
      chk("rst_valid", {31'd0, o_valid}, 0);
      chk("rst_data", {28'd0, o_data}, 0);
      chk("rst_sel", {29'd0, o_sel}, 0);
      chk("rst_err", {31'd0, o_err}, 0);

      // Manual mode, load select 5.
      t_in = 24'($urandom);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rq.push_back('{v: 1'b0, e: 1'b0});
      chk_en = 1;
      t_load = 1'b1;
      t_sel_in = 3'd5;
      step();
      t_load = 1'b0;
      repeat (6) begin
         t_in = 24'($urandom);
         step();
      end

      // Scan over channels 0,2,5 back to back.
      t_mode = 1'b1;
      t_en   = 6'b100101;
      repeat (9) begin
         t_in = 24'($urandom);
         step();
      end

      // Stall: inputs churn while the held sample must stay frozen.
      t_ready = 1'b0;
      repeat (4) begin
         t_in = 24'($urandom);
         t_en = 6'($urandom);
         step();
      end
      t_ready = 1'b1;
      t_en = 6'b100101;
      repeat (3) step();

      // Out-of-range select, then a valid manual select.
      t_mode = 1'b0;
      t_en = '1;
      t_load = 1'b1;
      t_sel_in = 3'd7;
      step();
      t_load = 1'b0;
      step();
      t_load = 1'b1;
      t_sel_in = 3'd6;
      step();
      t_sel_in = 3'd3;
      step();
      t_load = 1'b0;
      repeat (3) step();

      // All channels disabled while a sample is held, then channel 4 only.
      t_mode = 1'b1;
      t_en = 6'b100101;
      t_ready = 1'b0;
      repeat (2) step();
      t_en = '0;
      step();
      t_ready = 1'b1;
      repeat (3) step();
      t_en = 6'h10;
      repeat (3) step();

      // Asynchronous reset between edges while a sample is held.
      t_en = '1;
      t_ready = 1'b0;
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      chk_en = 0;
      chk("arst_valid", {31'd0, o_valid}, 0);
      chk("arst_data", {28'd0, o_data}, 0);
      chk("arst_sel", {29'd0, o_sel}, 0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rq.push_back('{v: 1'b0, e: 1'b0});
      chk_en = 1;
      t_ready = 1'b1;
      repeat (3) step();

      // Random traffic.
      repeat (400) begin
         t_in     = 24'($urandom);
         t_en     = ($urandom_range(0, 7) == 0) ? '0 : 6'($urandom);
         t_mode   = 1'($urandom);
         t_load   = ($urandom_range(0, 7) == 0);
         t_sel_in = 3'($urandom);
         t_ready  = ($urandom_range(0, 9) < 7);
         step();
      end

      // Drain and confirm nothing is left outstanding.
      t_load  = 1'b0;
      t_en    = '0;
      t_ready = 1'b1;
      repeat (3) step();
      @(negedge clk);
      #1;
      chk("drain_samples", tq.size(), 0);
      chk("drain_records", rq.size(), 0);
      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
